add_share_arb: RTL

- Shares one multi-cycle 32-bit carry-lookahead adder (RDCLA32-style) among NREQ requesters.
- The adder's carry tree is registered over several stages, but its final sum XOR reads the live operands. Operands must therefore be held stable for the full latency, and the adder cannot accept back-to-back ops.
- This block arbitrates round-robin and issues one op at a time, holding operands for that op.
- It captures sum/cout and returns the result tagged with the requester ID.
- It sits between the FP datapath units (exponent/mantissa adders of the multiplier) and the shared adder.

---
 rtl/add_share_arb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter that time-shares one multi-cycle 32-bit
// carry-lookahead adder among NREQ requesters. The adder's final sum XOR reads
// the live operands, so operands are latched at grant and held until the
// result has been captured. Results are returned tagged with the requester ID.
// Optional grant statistics are enabled by defining ADD_SHARE_STATS_EN.
`timescale 1ns/1ps

module add_share_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned ADD_LAT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_sum,
    input  logic                 add_cout,
`ifdef ADD_SHARE_STATS_EN
    input  logic [IDW-1:0]       stat_sel,
    input  logic                 stat_clr,
    output logic [15:0]          stat_cnt,
`endif
    output logic                 busy
);

    localparam int unsigned CNTW = (ADD_LAT > 2) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ADD_LAT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_d;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  sel_idx;
    logic [IDW-1:0]  cand;
    logic            sel_found;
    logic            grant_en;
    logic            done_en;

    // Pick the first valid requester at or after the round-robin pointer
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state, wait counter and grant/done strobes
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        req_ready = '0;
        grant_en  = 1'b0;
        done_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    grant_en           = 1'b1;
                    state_d            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt - CNTW'(1);
                if (cnt <= CNTW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_en = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Operand hold, ID tag, result capture and pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            id_q      <= '0;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            rsp_valid <= done_en;
            if (grant_en) begin
                add_a   <= req_a[32'(sel_idx)*32 +: 32];
                add_b   <= req_b[32'(sel_idx)*32 +: 32];
                add_cin <= req_cin[sel_idx];
                id_q    <= sel_idx;
            end
            if (done_en) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
                rsp_id   <= id_q;
                ptr      <= IDW'((32'(id_q) + 32'd1) % NREQ);
            end
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef ADD_SHARE_STATS_EN
    logic [15:0] stat_q [NREQ];

    // Per-requester saturating grant counters; a clear beats a same-cycle grant
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (grant_en && (stat_q[sel_idx] != 16'hFFFF)) begin
            stat_q[sel_idx] <= stat_q[sel_idx] + 16'd1;
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule
